// File: rtl/uart_mmio_if.sv
// Data-memory-style bus into the UART register window.
// Reads are combinational from ARADDR. Writes are strobed on the clock edge.
interface uart_mmio_if;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic [31:0] RDATA;
    logic [31:0] AWADDR;
    logic [31:0] WDATA;
    logic        AWVALID;

    modport master (output ARADDR, ARVALID, AWADDR, WDATA, AWVALID, input RDATA);
    modport slave  (input ARADDR, ARVALID, AWADDR, WDATA, AWVALID, output RDATA);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with a TX FIFO, a one-byte RX holding register and a
// programmable baud divider.
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
    parameter logic [15:0] CLKS_PER_BIT  = 16'd868,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       NRST,
    uart_mmio_if.slave bus,
    input  logic       RX_DSER,
    output logic       TX_DSER
);
    localparam int unsigned PW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(TX_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic       rd_hit, wr_hit;
    logic [1:0] rd_sel, wr_sel;
    logic       rx_pop, tx_push, status_wr, baud_wr;
    logic [31:0] rdata;
    logic       unused_bits;

    logic [15:0]   baud_q, baud_d;
    logic [7:0]    fifo_q [TX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          fifo_empty, tx_full, tx_pop, tx_idle;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;

    logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        rx_frame_err_q, rx_frame_err_d;

    assign rd_hit = (bus.ARADDR[31:4] == BASE_ADDR[31:4]);
    assign wr_hit = (bus.AWADDR[31:4] == BASE_ADDR[31:4]);
    assign rd_sel = bus.ARADDR[3:2];
    assign wr_sel = bus.AWADDR[3:2];
    assign unused_bits = ^{bus.ARADDR[1:0], bus.AWADDR[1:0], bus.WDATA[31:16]};

    assign rx_pop    = bus.ARVALID && rd_hit && (rd_sel == 2'd1);
    assign tx_push   = bus.AWVALID && wr_hit && (wr_sel == 2'd0) && !tx_full;
    assign status_wr = bus.AWVALID && wr_hit && (wr_sel == 2'd2);
    assign baud_wr   = bus.AWVALID && wr_hit && (wr_sel == 2'd3);

    assign fifo_empty = (fifo_cnt_q == '0);
    assign tx_full    = (fifo_cnt_q == FULL_CNT);
    assign tx_idle    = fifo_empty && (tx_state_q == TX_IDLE);

    always_comb begin
        rdata = '0;
        if (rd_hit) begin
            case (rd_sel)
                2'd1:    rdata = {24'b0, rx_byte_q};
                2'd2:    rdata = {27'b0, rx_frame_err_q, rx_overrun_q, rx_valid_q, tx_idle, tx_full};
                2'd3:    rdata = {16'b0, baud_q};
                default: rdata = '0;
            endcase
        end
    end
    assign bus.RDATA = rdata;

    always_comb begin
        baud_d = baud_q;
        if (baud_wr) begin
            baud_d = (bus.WDATA[15:0] < 16'd4) ? 16'd4 : bus.WDATA[15:0];
        end
    end

    always_comb begin
        wr_ptr_d   = tx_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = tx_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end

    always_ff @(posedge CLK) begin
        if (tx_push) begin
            fifo_q[wr_ptr_q] <= bus.WDATA[7:0];
        end
    end

    // Stop bit flows straight into the next start when the FIFO has data,
    // so frames are back-to-back with no idle cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_q[rd_ptr_q];
                    tx_div_d   = baud_q;
                    tx_cnt_d   = baud_q;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_cnt_d   = tx_div_q;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_cnt_d   = tx_div_q;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd1) begin
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = fifo_q[rd_ptr_q];
                        tx_div_d   = baud_q;
                        tx_cnt_d   = baud_q;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line is decoded from state so reset drives it high without waiting for a clock.
    always_comb begin
        case (tx_state_q)
            TX_START: TX_DSER = 1'b0;
            TX_DATA:  TX_DSER = tx_shift_q[0];
            default:  TX_DSER = 1'b1;
        endcase
    end

    assign rx_fall = rx_prev_q && !rx_sync_q;

    // Flag clears are applied first so a same-cycle set from the RX FSM wins.
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_div_d       = rx_div_q;
        rx_cnt_d       = rx_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_bit_d       = rx_bit_q;
        rx_byte_d      = rx_byte_q;
        rx_valid_d     = rx_valid_q;
        rx_overrun_d   = rx_overrun_q;
        rx_frame_err_d = rx_frame_err_q;

        if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
        if (status_wr && bus.WDATA[3]) begin
            rx_overrun_d = 1'b0;
        end
        if (status_wr && bus.WDATA[4]) begin
            rx_frame_err_d = 1'b0;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_div_d   = baud_q;
                    rx_cnt_d   = baud_q >> 1;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_cnt_d   = rx_div_q;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_cnt_d   = rx_div_q;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_state_d = RX_IDLE;
                    if (!rx_sync_q) begin
                        rx_frame_err_d = 1'b1;
                    end else if (!rx_valid_q || rx_pop) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_overrun_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX_DSER;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            baud_q         <= CLKS_PER_BIT;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            tx_state_q     <= TX_IDLE;
            tx_div_q       <= '0;
            tx_cnt_q       <= '0;
            tx_shift_q     <= '0;
            tx_bit_q       <= '0;
            rx_state_q     <= RX_IDLE;
            rx_div_q       <= '0;
            rx_cnt_q       <= '0;
            rx_shift_q     <= '0;
            rx_bit_q       <= '0;
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            baud_q         <= baud_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            tx_state_q     <= tx_state_d;
            tx_div_q       <= tx_div_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_shift_q     <= tx_shift_d;
            tx_bit_q       <= tx_bit_d;
            rx_state_q     <= rx_state_d;
            rx_div_q       <= rx_div_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_bit_q       <= rx_bit_d;
            rx_byte_q      <= rx_byte_d;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register table, serial waveform checks and
// randomized TX/RX traffic against a frame-level reference model.
module tb_uart_mmio;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_BD = BASE + 32'hC;

    logic CLK = 1'b0;
    logic NRST = 1'b0;
    logic RX_DSER = 1'b1;
    logic TX_DSER;

    uart_mmio_if bus();

    uart_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(16'd868), .TX_FIFO_DEPTH(4)) dut (
        .CLK(CLK), .NRST(NRST), .bus(bus), .RX_DSER(RX_DSER), .TX_DSER(TX_DSER)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // TX line decoder: recovers bytes and start times from TX_DSER.
    bit         mon_en = 1'b1;
    int         mon_baud = 8;
    int         mon_bad = 0;
    logic [7:0] got_q [$];
    int         start_q [$];

    initial begin : tx_mon
        logic       prev;
        logic [7:0] mb;
        int         st;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (mon_en && prev && !TX_DSER) begin
                st = cyc;
                repeat (mon_baud / 2) @(negedge CLK);
                if (TX_DSER !== 1'b0) mon_bad++;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_baud) @(negedge CLK);
                    mb[i] = TX_DSER;
                end
                repeat (mon_baud) @(negedge CLK);
                if (TX_DSER !== 1'b1) mon_bad++;
                got_q.push_back(mb);
                start_q.push_back(st);
                prev = 1'b1;
            end else begin
                prev = TX_DSER;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.AWADDR  = a;
        bus.WDATA   = d;
        bus.AWVALID = 1'b1;
        @(negedge CLK);
        bus.AWVALID = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.ARADDR  = a;
        bus.ARVALID = 1'b0;
        #1;
        d = bus.RDATA;
    endtask

    task automatic pop_read(input logic [31:0] a, output logic [31:0] d);
        bus.ARADDR  = a;
        bus.ARVALID = 1'b1;
        #1;
        d = bus.RDATA;
        @(negedge CLK);
        bus.ARVALID = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input int baud, input bit stop_ok);
        RX_DSER = 1'b0;
        repeat (baud) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX_DSER = b[i];
            repeat (baud) @(negedge CLK);
        end
        RX_DSER = stop_ok;
        repeat (baud) @(negedge CLK);
        RX_DSER = 1'b1;
        repeat (2 * baud) @(negedge CLK);
    endtask

    task automatic wait_tx_done(input int n, input int budget);
        logic [31:0] st;
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK);
            peek(A_ST, st);
            if (got_q.size() >= n && st[1]) break;
        end
        check("tx_done_in_time", (i < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [21];

    initial begin : main
        logic [31:0] d;
        logic [9:0]  fr;
        logic [7:0]  tx_bytes [6];
        logic [7:0]  b;
        int          baud, n, exp_n, act;
        bit          ok, m_valid, m_ovr, m_ferr;
        logic [7:0]  m_byte;

        bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.AWADDR = '0; bus.WDATA = '0; bus.AWVALID = 1'b0;

        // Reset state, with RX toggling while reset is held
        repeat (4) begin
            @(negedge CLK);
            RX_DSER = ~RX_DSER;
        end
        RX_DSER = 1'b1;
        check("rst_tx_line", {31'b0, TX_DSER}, 32'd1);
        peek(A_ST, d); check("rst_status", d, 32'h2);
        peek(A_BD, d); check("rst_bauddiv", d, 32'd868);
        @(negedge CLK);
        NRST = 1'b1;
        repeat (3) @(negedge CLK);

        vecs[0]  = '{1'b0, A_ST, 32'h0, 32'h2, "status_idle"};
        vecs[1]  = '{1'b0, A_BD, 32'h0, 32'd868, "baud_default"};
        vecs[2]  = '{1'b0, A_TX, 32'h0, 32'h0, "txdata_reads_0"};
        vecs[3]  = '{1'b0, A_RX, 32'h0, 32'h0, "rxdata_reset"};
        vecs[4]  = '{1'b0, BASE + 32'h10, 32'h0, 32'h0, "miss_above"};
        vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0, 32'h0, "miss_low"};
        vecs[6]  = '{1'b1, A_BD, 32'd2, 32'h0, ""};
        vecs[7]  = '{1'b0, A_BD, 32'h0, 32'd4, "baud_min_2"};
        vecs[8]  = '{1'b1, A_BD, 32'd0, 32'h0, ""};
        vecs[9]  = '{1'b0, A_BD, 32'h0, 32'd4, "baud_min_0"};
        vecs[10] = '{1'b1, A_BD, 32'd3, 32'h0, ""};
        vecs[11] = '{1'b0, A_BD, 32'h0, 32'd4, "baud_min_3"};
        vecs[12] = '{1'b1, A_BD, 32'd5, 32'h0, ""};
        vecs[13] = '{1'b0, A_BD, 32'h0, 32'd5, "baud_5"};
        vecs[14] = '{1'b1, A_BD, 32'hABCD_0010, 32'h0, ""};
        vecs[15] = '{1'b0, A_BD, 32'h0, 32'h10, "baud_upper_ignored"};
        vecs[16] = '{1'b1, 32'h0002_000C, 32'd100, 32'h0, ""};
        vecs[17] = '{1'b0, A_BD, 32'h0, 32'h10, "miss_write_ignored"};
        vecs[18] = '{1'b1, BASE + 32'hE, 32'd9, 32'h0, ""};
        vecs[19] = '{1'b0, A_BD, 32'h0, 32'd9, "byte_offset_ignored"};
        vecs[20] = '{1'b0, A_ST, 32'h0, 32'h2, "status_still_idle"};
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                peek(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].exp);
                @(negedge CLK);
            end
        end

        // TX single byte: exact waveform, 8 cycles per bit
        bus_write(A_BD, 32'd8);
        mon_baud = 8;
        got_q.delete(); start_q.delete();
        bus_write(A_TX, 32'h55);
        check("tx_pre_start_high", {31'b0, TX_DSER}, 32'd1);
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 80; k++) begin
            @(negedge CLK);
            check("tx_wave", {31'b0, TX_DSER}, {31'b0, fr[k / 8]});
        end
        peek(A_ST, d); check("tx_busy_in_stop", {31'b0, d[1]}, 32'd0);
        @(negedge CLK);
        peek(A_ST, d); check("tx_idle_after_frame", {31'b0, d[1]}, 32'd1);
        check("tx_single_count", got_q.size(), 32'd1);
        if (got_q.size() == 1) check("tx_single_byte", {24'b0, got_q[0]}, 32'h55);

        // TX FIFO full: 5 accepted (1 in shifter + 4 queued), 6th dropped
        got_q.delete(); start_q.delete();
        for (int i = 1; i <= 4; i++) bus_write(A_TX, i);
        peek(A_ST, d); check("tx_not_full_4", {31'b0, d[0]}, 32'd0);
        bus_write(A_TX, 32'h05);
        peek(A_ST, d); check("tx_full_5", {31'b0, d[0]}, 32'd1);
        bus_write(A_TX, 32'h06);
        wait_tx_done(5, 1000);
        repeat (100) @(negedge CLK);
        check("tx_full_count", got_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check("tx_full_byte", {24'b0, got_q[i]}, i + 1);
            if (i > 0) check("tx_back_to_back", start_q[i] - start_q[i-1], 32'd80);
        end

        // Randomized TX bursts against a queue model
        for (int t = 0; t < 6; t++) begin
            baud = $urandom_range(4, 12);
            n = $urandom_range(1, 6);
            bus_write(A_BD, baud);
            mon_baud = baud;
            got_q.delete(); start_q.delete();
            for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
            for (int i = 0; i < n; i++) bus_write(A_TX, {24'b0, tx_bytes[i]});
            exp_n = (n < 5) ? n : 5;
            wait_tx_done(exp_n, 20 * 13 * 6);
            check("tx_rand_count", got_q.size(), exp_n);
            for (int i = 0; i < exp_n && i < got_q.size(); i++) begin
                check("tx_rand_byte", {24'b0, got_q[i]}, {24'b0, tx_bytes[i]});
                if (i > 0) check("tx_rand_spacing", start_q[i] - start_q[i-1], 10 * baud);
            end
        end

        // RX receive and pop
        bus_write(A_BD, 32'd8);
        rx_frame(8'hA3, 8, 1'b1);
        peek(A_ST, d); check("rx_valid_set", d & 32'h1C, 32'h04);
        pop_read(A_RX, d); check("rx_data_a3", d, 32'hA3);
        peek(A_ST, d); check("rx_valid_cleared", d & 32'h1C, 32'h00);

        // RX overrun and W1C
        rx_frame(8'h11, 8, 1'b1);
        rx_frame(8'h22, 8, 1'b1);
        peek(A_RX, d); check("rx_overrun_keeps_old", d, 32'h11);
        peek(A_ST, d); check("rx_overrun_set", d & 32'h1C, 32'h0C);
        bus_write(A_ST, 32'h8);
        peek(A_ST, d); check("rx_overrun_w1c", d & 32'h1C, 32'h04);
        pop_read(A_RX, d); check("rx_overrun_pop", d, 32'h11);

        // RX glitch: 2-cycle low pulse is a false start
        RX_DSER = 1'b0;
        repeat (2) @(negedge CLK);
        RX_DSER = 1'b1;
        repeat (30) @(negedge CLK);
        peek(A_ST, d); check("rx_glitch_no_flags", d & 32'h1C, 32'h00);

        // RX framing error: byte discarded, rx_valid unchanged
        rx_frame(8'h5A, 8, 1'b0);
        peek(A_ST, d); check("rx_frame_err", d & 32'h1C, 32'h10);
        peek(A_RX, d); check("rx_frame_err_discard", d, 32'h11);
        bus_write(A_ST, 32'h10);
        peek(A_ST, d); check("rx_frame_err_w1c", d & 32'h1C, 32'h00);

        // Randomized RX frames against a holding-register model
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h11;
        for (int t = 0; t < 16; t++) begin
            baud = $urandom_range(4, 12);
            bus_write(A_BD, baud);
            b = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            rx_frame(b, baud, ok);
            if (!ok) m_ferr = 1'b1;
            else if (!m_valid) begin m_byte = b; m_valid = 1'b1; end
            else m_ovr = 1'b1;
            peek(A_ST, d); check("rx_rand_status", d & 32'h1C, {27'b0, m_ferr, m_ovr, m_valid, 2'b0});
            peek(A_RX, d); check("rx_rand_data", d, {24'b0, m_byte});
            act = $urandom_range(0, 2);
            if (act == 0) begin
                pop_read(A_RX, d); check("rx_rand_pop", d, {24'b0, m_byte});
                m_valid = 1'b0;
            end else if (act == 1) begin
                d = $urandom & 32'h18;
                bus_write(A_ST, d);
                if (d[3]) m_ovr = 1'b0;
                if (d[4]) m_ferr = 1'b0;
            end
            peek(A_ST, d); check("rx_rand_after", d & 32'h1C, {27'b0, m_ferr, m_ovr, m_valid, 2'b0});
            @(negedge CLK);
        end

        check("tx_monitor_framing", mon_bad, 32'd0);

        // Reset mid-frame: line returns high without a clock edge, frame lost
        mon_en = 1'b0;
        bus_write(A_BD, 32'd8);
        bus_write(A_TX, 32'h00);
        repeat (20) @(negedge CLK);
        check("tx_mid_frame_low", {31'b0, TX_DSER}, 32'd0);
        #2 NRST = 1'b0;
        #1 check("tx_async_reset_high", {31'b0, TX_DSER}, 32'd1);
        peek(A_ST, d); check("reset_mid_status", d, 32'h2);
        peek(A_BD, d); check("reset_mid_baud", d, 32'd868);
        @(negedge CLK);
        NRST = 1'b1;
        repeat (200) @(negedge CLK);
        check("tx_frame_lost", {31'b0, TX_DSER}, 32'd1);
        peek(A_ST, d); check("post_reset_status", d, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
